// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - per-channel duty slew limiter feeding the PWM generator DC_bus
//
// Holds a target duty per channel (written over WrValid/WrReady) and, once per
// ramp tick, moves every channel's current duty toward its target by at most Step.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   WrValid  write request
//   WrReady  write accepted when WrValid && WrReady
//   WrChan   channel index of the write (indices >= NPWM are accepted and ignored)
//   WrDuty   target duty for WrChan
//   DC_bus   current duty, channel i at [i*Resolution +: Resolution]
//   Settled  bit i set when current[i] == target[i]
//   Busy     high while the ramp scan is running

module pwm_duty_ramp #(
  parameter int SysClk     = 125000000,
  parameter int NPWM       = 5,
  parameter int Resolution = 8,
  parameter int RampHz     = 1000,
  parameter int Step       = 1,
  localparam int CHW       = (NPWM > 1) ? $clog2(NPWM) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       WrValid,
  output logic                       WrReady,
  input  logic [CHW-1:0]             WrChan,
  input  logic [Resolution-1:0]      WrDuty,
  output logic [NPWM*Resolution-1:0] DC_bus,
  output logic [NPWM-1:0]            Settled,
  output logic                       Busy
);

  localparam int TDIV = SysClk / RampHz;
  localparam int CNTW = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam logic [Resolution:0] STEP_W = (Resolution + 1)'(Step);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         tick_cnt;
  logic                    tick;
  logic                    ready_en;
  logic [CHW-1:0]          idx_q, idx_d;
  logic                    wr_fire;
  logic [Resolution-1:0]   target  [NPWM];
  logic [Resolution-1:0]   current [NPWM];

  // One slew step, done one bit wider so the difference and the +/- Step
  // never wrap; the result lands exactly on target when within reach.
  function automatic logic [Resolution-1:0] slew(input logic [Resolution-1:0] cur,
                                                 input logic [Resolution-1:0] tgt);
    logic [Resolution:0] c, t, d;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    d = (t >= c) ? (t - c) : (c - t);
    if (STEP_W == '0 || d <= STEP_W) begin
      return tgt;
    end else if (t > c) begin
      return Resolution'(c + STEP_W);
    end else begin
      return Resolution'(c - STEP_W);
    end
  endfunction

  // Free-running tick divider; never stalled by writes or the scan.
  assign tick = (tick_cnt == CNTW'(TDIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ready_en keeps WrReady low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ready_en <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    WrReady = 1'b0;
    Busy    = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick pre-empts any write in the same cycle; the requester holds WrValid.
        WrReady = ready_en && !tick;
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        Busy = 1'b1;
        if (idx_q == CHW'(NPWM - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_fire = WrValid && WrReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPWM; i++) begin
        target[i]  <= '0;
        current[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPWM; i++) begin
        if (wr_fire && WrChan == CHW'(i)) begin
          target[i] <= WrDuty;
        end
        if (state_q == SCAN && idx_q == CHW'(i)) begin
          current[i] <= slew(current[i], target[i]);
        end
      end
    end
  end

  always_comb begin
    DC_bus  = '0;
    Settled = '0;
    for (int i = 0; i < NPWM; i++) begin
      DC_bus[i*Resolution +: Resolution] = current[i];
      Settled[i] = (current[i] == target[i]);
    end
  end

endmodule
